// File: rtl/sensor_read_controller_if.sv
// sensor_read_controller_if: request/result bus toward the system plus the DHT11 decoder bus.
// Latency: none, wires only.
// Backpressure: none; the request side is a one-cycle pulse and the result is a done pulse.
// master = system/decoder side that drives request and decoder outputs; slave = the controller.
interface sensor_read_controller_if;
   logic       request;
   logic       dec_enable;
   logic       dec_reset;
   logic       dec_hold;
   logic       dec_error;
   logic [7:0] dec_hum_int;
   logic [7:0] dec_hum_float;
   logic [7:0] dec_temp_int;
   logic [7:0] dec_temp_float;
   logic [7:0] dec_checksum;
   logic       busy;
   logic       done;
   logic [1:0] status;
   logic       data_valid;
   logic [7:0] humidity;
   logic [7:0] humidity_frac;
   logic [7:0] temperature;
   logic [7:0] temperature_frac;
   logic [3:0] retry_count;

   modport master (
      output request, dec_hold, dec_error,
      output dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float, dec_checksum,
      input  dec_enable, dec_reset, busy, done, status, data_valid,
      input  humidity, humidity_frac, temperature, temperature_frac, retry_count
   );

   modport slave (
      input  request, dec_hold, dec_error,
      input  dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float, dec_checksum,
      output dec_enable, dec_reset, busy, done, status, data_valid,
      output humidity, humidity_frac, temperature, temperature_frac, retry_count
   );
endinterface

// File: rtl/sensor_read_controller.sv
// sensor_read_controller: sequences DHT11 decoder reads, classifies the frame, retries, latches good data.
// Latency: request -> dec_reset next cycle; dec_hold fall seen at M -> done at M+2.
// Backpressure: none; request is accepted only in IDLE and ignored (not queued) while busy.
// Ports: clock, reset (synchronous, active-high); bus = request/busy/done/status/data toward the
//        system and dec_* toward the decoder (sensor_read_controller_if.slave).
module sensor_read_controller #(
   parameter int unsigned TIMEOUT_CYCLES     = 5_000_000,
   parameter int unsigned RETRY_GAP_CYCLES   = 50_000_000,
   parameter int unsigned ERR_PERSIST_CYCLES = 500_000,
   parameter int unsigned MAX_RETRIES        = 3
) (
   input logic                     clock,
   input logic                     reset,
   sensor_read_controller_if.slave bus
);
   localparam logic [31:0] WAIT_BUSY_LAST = 32'd15;
   localparam logic [31:0] TIMEOUT_LAST   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] GAP_LAST       = 32'(RETRY_GAP_CYCLES - 1);
   localparam logic [31:0] ERR_PERSIST    = 32'(ERR_PERSIST_CYCLES);
   localparam logic [3:0]  RETRY_LIMIT    = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, CHECK, GAP, REPORT} state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [31:0] err_run;
   logic        err_seen;
   logic [3:0]  retries;

   logic [9:0]  sum;
   logic        sum_bad;
   logic        frame_bad;
   logic        fail_go;
   logic        ok_go;
   logic [1:0]  fail_code;

   // Attempt outcome for the current cycle; only WAIT_BUSY, WAIT_DONE and CHECK can end an attempt.
   always_comb begin
      sum = {2'b00, bus.dec_hum_int} + {2'b00, bus.dec_hum_float}
          + {2'b00, bus.dec_temp_int} + {2'b00, bus.dec_temp_float};
      // Checksum compares the low byte of the 10-bit sum only.
      sum_bad   = |((sum ^ {2'b00, bus.dec_checksum}) & 10'h0FF);
      frame_bad = err_seen ||
                  ({bus.dec_hum_int, bus.dec_hum_float, bus.dec_temp_int,
                    bus.dec_temp_float, bus.dec_checksum} == 40'd0);
      fail_go   = 1'b0;
      ok_go     = 1'b0;
      fail_code = 2'b11;
      case (state)
         WAIT_BUSY: fail_go = !bus.dec_hold && (cnt == WAIT_BUSY_LAST);
         WAIT_DONE: fail_go = bus.dec_hold && (cnt == TIMEOUT_LAST);
         CHECK: begin
            if (frame_bad) begin
               fail_go   = 1'b1;
               fail_code = 2'b10;
            end else if (sum_bad) begin
               fail_go   = 1'b1;
               fail_code = 2'b01;
            end else begin
               ok_go = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state                <= IDLE;
         cnt                  <= '0;
         err_run              <= '0;
         err_seen             <= 1'b0;
         retries              <= '0;
         bus.dec_enable       <= 1'b0;
         bus.dec_reset        <= 1'b0;
         bus.busy             <= 1'b0;
         bus.done             <= 1'b0;
         bus.status           <= '0;
         bus.data_valid       <= 1'b0;
         bus.humidity         <= '0;
         bus.humidity_frac    <= '0;
         bus.temperature      <= '0;
         bus.temperature_frac <= '0;
         bus.retry_count      <= '0;
      end else begin
         bus.dec_enable <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.request) begin
                  state         <= START;
                  cnt           <= '0;
                  retries       <= '0;
                  bus.busy      <= 1'b1;
                  bus.dec_reset <= 1'b1;
               end
            end
            START: begin
               bus.dec_reset <= 1'b0;
               state         <= WAIT_BUSY;
               cnt           <= '0;
               err_run       <= '0;
               err_seen      <= 1'b0;
            end
            WAIT_BUSY: begin
               if (bus.dec_hold) begin
                  state <= WAIT_DONE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            WAIT_DONE: begin
               // Only an error run of ERR_PERSIST cycles counts; short pulses occur in good frames.
               if (bus.dec_error) begin
                  err_run <= err_run + 32'd1;
                  if (err_run + 32'd1 >= ERR_PERSIST) err_seen <= 1'b1;
               end else begin
                  err_run <= '0;
               end
               if (!bus.dec_hold) begin
                  state <= CHECK;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            CHECK: cnt <= '0;
            GAP: begin
               if (cnt == GAP_LAST) begin
                  state         <= START;
                  cnt           <= '0;
                  bus.dec_reset <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            REPORT: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
               cnt      <= '0;
            end
            default: state <= IDLE;
         endcase

         // Attempt outcome overrides the per-state next-state above. Result registers are
         // written on entry to REPORT so they are valid in the same cycle as done.
         if (fail_go) begin
            cnt <= '0;
            if (retries < RETRY_LIMIT) begin
               retries <= retries + 4'd1;
               state   <= GAP;
            end else begin
               state           <= REPORT;
               bus.done        <= 1'b1;
               bus.status      <= fail_code;
               bus.retry_count <= retries;
            end
         end else if (ok_go) begin
            cnt                  <= '0;
            state                <= REPORT;
            bus.done             <= 1'b1;
            bus.status           <= 2'b00;
            bus.data_valid       <= 1'b1;
            bus.humidity         <= bus.dec_hum_int;
            bus.humidity_frac    <= bus.dec_hum_float;
            bus.temperature      <= bus.dec_temp_int;
            bus.temperature_frac <= bus.dec_temp_float;
            bus.retry_count      <= retries;
         end
      end
   end
endmodule

// File: tb/tb_sensor_read_controller.sv
// tb_sensor_read_controller: directed and random transactions against a behavioural decoder,
// with a transaction-level model predicting pulse/done cycles and result registers.
// Ports: none (top-level bench).
module tb_sensor_read_controller;
   localparam int T  = 200;
   localparam int G  = 20;
   localparam int EP = 10;
   localparam int MR = 2;

   typedef struct {
      bit         resp;
      int         d;
      int         l;
      int         elen;
      logic [7:0] hi, hf, ti, tf, ck;
   } att_t;

   typedef struct packed {
      logic [1:0] st;
      logic       dv;
      logic [7:0] h, hf, t, tf;
      logic [3:0] rc;
   } res_t;

   logic clock = 1'b0;
   logic reset;
   sensor_read_controller_if bus();

   sensor_read_controller #(
      .TIMEOUT_CYCLES(T), .RETRY_GAP_CYCLES(G), .ERR_PERSIST_CYCLES(EP), .MAX_RETRIES(MR)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   att_t att[3];
   att_t dcur;
   int   d_idx = 0;
   int   dp = 0;
   int   dpulses = 0;
   bit   dact = 1'b0;
   int   exp_rst_q[$];
   res_t m_old = '0;
   res_t m_new = '0;
   int   m_bs = -10;
   int   m_dc = -10;
   int   en_cyc = 5;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic set_att(input int a, input bit resp, input int d, input int l, input int elen,
                          input logic [7:0] hi, hf, ti, tf, ck);
      att[a].resp = resp; att[a].d = d; att[a].l = l; att[a].elen = elen;
      att[a].hi = hi; att[a].hf = hf; att[a].ti = ti; att[a].tf = tf; att[a].ck = ck;
   endtask

   task automatic rand_att(input int a);
      int r;
      att[a].resp = ($urandom_range(9) != 0);
      att[a].d    = int'($urandom_range(6, 1));
      att[a].l    = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(150, 30));
      att[a].elen = ($urandom_range(4) == 0) ? int'($urandom_range(15, 10)) : int'($urandom_range(9, 0));
      att[a].hi = 8'($urandom); att[a].hf = 8'($urandom);
      att[a].ti = 8'($urandom); att[a].tf = 8'($urandom);
      r = int'($urandom_range(9));
      if (r == 0) begin
         att[a].hi = 0; att[a].hf = 0; att[a].ti = 0; att[a].tf = 0; att[a].ck = 0;
      end else if (r < 7) begin
         att[a].ck = att[a].hi + att[a].hf + att[a].ti + att[a].tf;
      end else begin
         att[a].ck = 8'($urandom);
      end
   endtask

   // Predict the whole transaction from the attempt descriptions and drive request this cycle.
   task automatic start_txn();
      int n, p, f, code, a;
      bit fin;
      n = cyc; p = n + 1; f = 0; code = 0; a = 0; fin = 1'b0;
      m_old = m_new;
      while (!fin) begin
         exp_rst_q.push_back(p);
         if (!att[a].resp) begin
            f = p + 16; code = 3;
         end else if (att[a].l == 0) begin
            f = p + att[a].d + T; code = 3;
         end else begin
            f = p + att[a].d + att[a].l + 1;
            if (att[a].elen >= EP ||
                {att[a].hi, att[a].hf, att[a].ti, att[a].tf, att[a].ck} == 40'd0)
               code = 2;
            else if ((int'(att[a].hi) + int'(att[a].hf) + int'(att[a].ti) + int'(att[a].tf)) % 256
                     != int'(att[a].ck))
               code = 1;
            else
               code = 0;
         end
         if (code == 0 || a == MR) fin = 1'b1;
         else begin
            a++;
            p = f + 1 + G;
         end
      end
      m_new.st = code[1:0];
      m_new.rc = a[3:0];
      if (code == 0) begin
         m_new.dv = 1'b1;
         m_new.h  = att[a].hi; m_new.hf = att[a].hf;
         m_new.t  = att[a].ti; m_new.tf = att[a].tf;
      end
      m_bs = n + 1;
      m_dc = f + 1;
      d_idx = 0;
      dpulses = 0;
      bus.request = 1'b1;
   endtask

   task automatic run_txn(input bit stray);
      start_txn();
      while (cyc < m_dc + 1) begin
         step();
         bus.request = stray && (cyc == m_bs + 4);
      end
      bus.request = 1'b0;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_busy"}, bus.busy, 0);
      chk({p, "_done"}, bus.done, 0);
      chk({p, "_status"}, bus.status, 0);
      chk({p, "_dv"}, bus.data_valid, 0);
      chk({p, "_hum"}, bus.humidity, 0);
      chk({p, "_temp"}, bus.temperature, 0);
      chk({p, "_retry"}, bus.retry_count, 0);
      chk({p, "_dec_reset"}, bus.dec_reset, 0);
      chk({p, "_dec_enable"}, bus.dec_enable, 0);
   endtask

   // Behavioural decoder: on each dec_reset pulse it takes the next attempt description.
   initial begin : decoder
      int k;
      bus.dec_hold = 0; bus.dec_error = 0;
      bus.dec_hum_int = 0; bus.dec_hum_float = 0; bus.dec_temp_int = 0;
      bus.dec_temp_float = 0; bus.dec_checksum = 0;
      forever begin
         step();
         if (bus.dec_reset === 1'b1) begin
            dcur = att[(d_idx < 3) ? d_idx : 2];
            d_idx++;
            dpulses++;
            dp = cyc;
            dact = 1'b1;
            bus.dec_hum_int = dcur.hi; bus.dec_hum_float = dcur.hf;
            bus.dec_temp_int = dcur.ti; bus.dec_temp_float = dcur.tf;
            bus.dec_checksum = dcur.ck;
         end
         k = cyc - dp;
         bus.dec_hold  = dact && dcur.resp && (k >= dcur.d) && (dcur.l == 0 || k < dcur.d + dcur.l);
         bus.dec_error = dact && dcur.resp && (dcur.elen > 0) &&
                         (k >= dcur.d + 3) && (k < dcur.d + 3 + dcur.elen);
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin : compare
      int   c;
      bit   e_rst;
      res_t r;
      forever begin
         @(negedge clock);
         if (cyc >= 1) begin
            c = cyc;
            e_rst = 1'b0;
            if (exp_rst_q.size() > 0 && exp_rst_q[0] == c) begin
               e_rst = 1'b1;
               void'(exp_rst_q.pop_front());
            end
            r = (c >= m_dc) ? m_new : m_old;
            if (c < en_cyc) begin
               r = '0;
               e_rst = 1'b0;
            end
            chk("dec_enable", bus.dec_enable, 32'(c >= en_cyc));
            chk("dec_reset", bus.dec_reset, 32'(e_rst));
            chk("done", bus.done, 32'(c == m_dc && c >= en_cyc));
            chk("busy", bus.busy, 32'(c >= m_bs && c <= m_dc && c >= en_cyc));
            chk("status", bus.status, 32'(r.st));
            chk("data_valid", bus.data_valid, 32'(r.dv));
            chk("humidity", bus.humidity, 32'(r.h));
            chk("humidity_frac", bus.humidity_frac, 32'(r.hf));
            chk("temperature", bus.temperature, 32'(r.t));
            chk("temperature_frac", bus.temperature_frac, 32'(r.tf));
            chk("retry_count", bus.retry_count, 32'(r.rc));
         end
      end
   end

   initial begin : stimulus
      int n;
      bus.request = 1'b0;
      reset = 1'b1;
      repeat (4) step();
      chk_zero("por");
      reset = 1'b0;
      repeat (3) step();

      // Good frame on the first attempt.
      set_att(0, 1, 2, 40, 0, 8'd45, 8'd0, 8'd23, 8'd0, 8'd68);
      run_txn(1'b0);
      chk("good_status", bus.status, 0);
      chk("good_hum", bus.humidity, 45);
      chk("good_temp", bus.temperature, 23);
      chk("good_dv", bus.data_valid, 1);
      chk("good_retry", bus.retry_count, 0);
      chk("good_pulses", dpulses, 1);
      repeat (2) step();

      // Checksum wrong on every attempt: data keeps the previous good frame.
      for (int a = 0; a < 3; a++) set_att(a, 1, 3, 35, 0, 8'd50, 8'd1, 8'd20, 8'd2, 8'd67);
      run_txn(1'b1);
      chk("cks_status", bus.status, 1);
      chk("cks_retry", bus.retry_count, 2);
      chk("cks_hum", bus.humidity, 45);
      chk("cks_dv", bus.data_valid, 1);
      chk("cks_pulses", dpulses, 3);

      // Short error pulse inside a good frame is ignored (back-to-back request).
      set_att(0, 1, 1, 40, 5, 8'd60, 8'd5, 8'd25, 8'd3, 8'd93);
      run_txn(1'b0);
      chk("short_err_status", bus.status, 0);
      chk("short_err_hum", bus.humidity, 60);

      // Persistent error on attempt 1, good frame on attempt 2.
      set_att(0, 1, 2, 40, 15, 8'd10, 8'd0, 8'd10, 8'd0, 8'd20);
      set_att(1, 1, 4, 50, 0, 8'd70, 8'd0, 8'd30, 8'd0, 8'd100);
      run_txn(1'b0);
      chk("long_err_status", bus.status, 0);
      chk("long_err_retry", bus.retry_count, 1);
      chk("long_err_hum", bus.humidity, 70);

      // Decoder never responds on attempt 1, good frame on attempt 2.
      set_att(0, 0, 1, 40, 0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      set_att(1, 1, 2, 40, 0, 8'd33, 8'd1, 8'd21, 8'd4, 8'd59);
      run_txn(1'b0);
      chk("noresp_retry", bus.retry_count, 1);
      chk("noresp_hum", bus.humidity, 33);

      // dec_hold never falls: every attempt times out.
      for (int a = 0; a < 3; a++) set_att(a, 1, 2, 0, 0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd10);
      run_txn(1'b0);
      chk("tmo_status", bus.status, 3);
      chk("tmo_retry", bus.retry_count, 2);
      chk("tmo_hum", bus.humidity, 33);
      repeat (3) step();

      // reset together with request in WAIT_DONE.
      set_att(0, 1, 2, 100, 0, 8'd40, 8'd0, 8'd20, 8'd0, 8'd60);
      start_txn();
      step();
      bus.request = 1'b0;
      repeat (8) step();
      reset = 1'b1;
      bus.request = 1'b1;
      dact = 1'b0;
      step();
      chk_zero("mid_reset");
      exp_rst_q.delete();
      m_old = '0;
      m_new = '0;
      m_bs = -10;
      m_dc = -10;
      en_cyc = cyc + 1;
      reset = 1'b0;
      bus.request = 1'b0;
      repeat (30) step();
      chk("post_reset_dv", bus.data_valid, 0);
      chk("post_reset_pulses", dpulses, 1);

      // Randomized transactions.
      for (int t = 0; t < 14; t++) begin
         for (int a = 0; a < 3; a++) rand_att(a);
         run_txn($urandom_range(1) == 1);
         n = int'($urandom_range(3));
         repeat (n) step();
      end
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
